sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  N-port round-robin arbiter that merges NUM_PORTS sdram_ctrl-style requesters (wr byte mask, rd,
//  rdy/rvalid/wvalid/error handshake) onto the single request port of the SDRAM controller.
//  Sits between bus masters (CPU, DMA, video) and the controller.
//  Exactly one transaction is outstanding at a time; responses route back to the granted port only.
// PARAMETERS
//  NUM_PORTS       4               number of upstream requesters (>=2)
//  ADDR_WIDTH      32              byte address width
//  DATA_WIDTH      32              data width
//  WORD_LEN        DATA_WIDTH/8    byte-enable bits per write
//  TIMEOUT_CYCLES  1024            watchdog limit; used only with SDRAM_ARB_TIMEOUT_EN
// PORTS
//  clk            in   1                      clock
//  rst            in   1                      synchronous reset, active-high
//  up_wr          in   NUM_PORTS*WORD_LEN     per-port write byte mask (port i at [i*WORD_LEN+:WORD_LEN])
//  up_rd          in   NUM_PORTS              per-port read request
//  up_addr        in   NUM_PORTS*ADDR_WIDTH   per-port address
//  up_write_data  in   NUM_PORTS*DATA_WIDTH   per-port write data
//  up_rdy         out  NUM_PORTS              request accepted (granted port only)
//  up_rvalid      out  NUM_PORTS              read data valid (1-cycle pulse)
//  up_wvalid      out  NUM_PORTS              write complete (1-cycle pulse)
//  up_error       out  NUM_PORTS              transaction error (1-cycle pulse)
//  up_read_data   out  DATA_WIDTH             shared read data; qualify with up_rvalid[i]
//  dn_wr, dn_rd, dn_addr, dn_write_data  out  WORD_LEN/1/ADDR_WIDTH/DATA_WIDTH   to controller
//  dn_rdy, dn_rvalid, dn_wvalid, dn_error   in  1 each                           from controller
//  dn_read_data   in   DATA_WIDTH             from controller
//  grant_id       out  $clog2(NUM_PORTS)      current or last granted port
// BEHAVIOUR
//  - req[i] = |up_wr[i] | up_rd[i]. If both are set, the request is a write and rd is ignored.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: if any req, choose the first requesting port searching last_grant+1 .. wrapping modulo NUM_PORTS.
//    On that edge, register grant_id, op type, addr, write data and mask; next state is ISSUE.
//    Arbitration latency is 1 cycle.
//  - ISSUE: dn_wr/dn_rd/dn_addr/dn_write_data driven from the captured registers and held.
//    up_rdy[g] = dn_rdy (combinational). On a cycle with dn_rdy=1, next state is WAIT.
//    dn_wr/dn_rd drop to 0 on that edge.
//  - WAIT: write ends on dn_wvalid, read ends on dn_rvalid. up_wvalid[g]/up_rvalid[g] mirror it in the
//    same cycle. up_read_data = dn_read_data always. Next state IDLE; last_grant <= g.
//  - dn_error in ISSUE or WAIT: up_error[g]=1 same cycle, dn_wr/dn_rd drop, next state IDLE.
//  - Mismatched response (dn_rvalid during a write, dn_wvalid during a read) is ignored.
//    Any response in IDLE is ignored.
//  - Requester deasserting before up_rdy: the captured request is still issued and its response
//    still routed (no cancel).
//  - Non-granted ports: up_rdy/up_rvalid/up_wvalid/up_error = 0.
//  - Minimum 3 cycles per transaction plus controller latency. Strict round-robin: no port waits
//    more than NUM_PORTS-1 transactions.
//  - Reset (any state, incl. mid-transaction): state IDLE, all dn_*/up_* outputs 0, grant_id 0,
//    last_grant = NUM_PORTS-1 (port 0 first priority). Late controller responses after reset are dropped.
// CONFIGURATION
//  - SDRAM_ARB_TIMEOUT_EN defined: a counter clears on IDLE->ISSUE and increments in ISSUE/WAIT.
//    On reaching TIMEOUT_CYCLES: up_error[g] pulses 1 cycle, dn_wr/dn_rd drop, next state IDLE.
//  - SDRAM_ARB_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; TIMEOUT_CYCLES is unused.
// TESTING
//  1. Port 2 write mask 4'hF, addr 0x100, data 0xDEADBEEF; dn_rdy after 3 cycles, dn_wvalid 5 later
//     -> dn_* carry the values; up_rdy[2] and up_wvalid[2] are single pulses; other ports stay 0.
//  2. All 4 ports read simultaneously after reset -> grants in order 0,1,2,3,0.
//     up_rvalid pulses only on the granted port with dn_read_data.
//  3. Port 1 read, controller returns dn_error in WAIT -> up_error[1] pulse, FSM IDLE,
//     next request granted normally.
//  4. Assert rst while in WAIT, then dn_rvalid 2 cycles later -> no up_rvalid. Outputs 0.
//     First grant after reset is port 0.
//  5. Port 0 wr=4'h3 and rd=1 together -> dn_wr=4'h3, dn_rd=0; completion via dn_wvalid only.
//  6. SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, controller never responds -> up_error[g] pulses
//     16 cycles after ISSUE entry; FSM returns to IDLE.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging NUM_PORTS requesters onto one SDRAM controller port.
// Optional watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_LEN       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*WORD_LEN-1:0]    up_wr,
    input  logic [NUM_PORTS-1:0]             up_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  up_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  up_write_data,
    output logic [NUM_PORTS-1:0]             up_rdy,
    output logic [NUM_PORTS-1:0]             up_rvalid,
    output logic [NUM_PORTS-1:0]             up_wvalid,
    output logic [NUM_PORTS-1:0]             up_error,
    output logic [DATA_WIDTH-1:0]            up_read_data,
    output logic [WORD_LEN-1:0]              dn_wr,
    output logic                             dn_rd,
    output logic [ADDR_WIDTH-1:0]            dn_addr,
    output logic [DATA_WIDTH-1:0]            dn_write_data,
    input  logic                             dn_rdy,
    input  logic                             dn_rvalid,
    input  logic                             dn_wvalid,
    input  logic                             dn_error,
    input  logic [DATA_WIDTH-1:0]            dn_read_data,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id
);

    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                  state, state_n;
    logic [GW-1:0]           grant_q, last_grant, pick, cand;
    logic                    any_req, is_wr, txn_end, timeout;
    logic [NUM_PORTS-1:0]    req, g_onehot;
    logic [WORD_LEN-1:0]     mask_q, sel_mask;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    int unsigned             idx;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            req[i] = (|up_wr[i*WORD_LEN +: WORD_LEN]) | up_rd[i];
    end

    // Search starts one past the last served port so every port gets a turn.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx  = (int'(last_grant) + k) % NUM_PORTS;
            cand = idx[GW-1:0];
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    assign sel_mask = up_wr[pick*WORD_LEN +: WORD_LEN];

    always_comb begin
        g_onehot          = '0;
        g_onehot[grant_q] = 1'b1;
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state != S_IDLE) && (to_cnt == CW'(TIMEOUT_CYCLES));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant_q    <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
            is_wr      <= 1'b0;
            mask_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && any_req) begin
                grant_q <= pick;
                mask_q  <= sel_mask;
                is_wr   <= |sel_mask;
                addr_q  <= up_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                data_q  <= up_write_data[pick*DATA_WIDTH +: DATA_WIDTH];
            end
            if (txn_end)
                last_grant <= grant_q;
        end
    end

    always_comb begin
        state_n   = state;
        txn_end   = 1'b0;
        dn_wr     = '0;
        dn_rd     = 1'b0;
        up_rdy    = '0;
        up_rvalid = '0;
        up_wvalid = '0;
        up_error  = '0;
        case (state)
            S_IDLE: begin
                if (any_req)
                    state_n = S_ISSUE;
            end
            S_ISSUE: begin
                dn_wr  = is_wr ? mask_q : '0;
                dn_rd  = !is_wr;
                up_rdy = dn_rdy ? g_onehot : '0;
                if (dn_error || timeout) begin
                    up_error = g_onehot;
                    txn_end  = 1'b1;
                    state_n  = S_IDLE;
                end else if (dn_rdy) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dn_error || timeout) begin
                    up_error = g_onehot;
                    txn_end  = 1'b1;
                    state_n  = S_IDLE;
                end else if (is_wr && dn_wvalid) begin
                    up_wvalid = g_onehot;
                    txn_end   = 1'b1;
                    state_n   = S_IDLE;
                end else if (!is_wr && dn_rvalid) begin
                    up_rvalid = g_onehot;
                    txn_end   = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign dn_addr       = addr_q;
    assign dn_write_data = data_q;
    assign up_read_data  = dn_read_data;
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: transaction-level model plus directed scenarios.
// Define SDRAM_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_sdram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*WL-1:0]   up_wr = '0;
    logic [N-1:0]      up_rd = '0;
    logic [N*AW-1:0]   up_addr = '0;
    logic [N*DW-1:0]   up_write_data = '0;
    logic [N-1:0]      up_rdy, up_rvalid, up_wvalid, up_error;
    logic [DW-1:0]     up_read_data;
    logic [WL-1:0]     dn_wr;
    logic              dn_rd;
    logic [AW-1:0]     dn_addr;
    logic [DW-1:0]     dn_write_data;
    logic              dn_rdy = 1'b0, dn_rvalid = 1'b0, dn_wvalid = 1'b0, dn_error = 1'b0;
    logic [DW-1:0]     dn_read_data = '0;
    logic [1:0]        grant_id;

    sdram_port_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_write_data(up_write_data),
        .up_rdy(up_rdy), .up_rvalid(up_rvalid), .up_wvalid(up_wvalid), .up_error(up_error),
        .up_read_data(up_read_data),
        .dn_wr(dn_wr), .dn_rd(dn_rd), .dn_addr(dn_addr), .dn_write_data(dn_write_data),
        .dn_rdy(dn_rdy), .dn_rvalid(dn_rvalid), .dn_wvalid(dn_wvalid), .dn_error(dn_error),
        .dn_read_data(dn_read_data), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: m_phase 0 = nothing in flight, 1 = offered to controller,
    // 2 = accepted and awaiting response.
    int              m_phase = 0, m_g = 0, m_last = N - 1, m_cnt = 0;
    logic            m_wr = 1'b0;
    logic [WL-1:0]   m_mask = '0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;

    function automatic bit m_timeout();
`ifdef SDRAM_ARB_TIMEOUT_EN
        return (m_phase != 0) && (m_cnt == TO);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model
        bit to;
        int p;
        to = m_timeout();
        if (rst) begin
            m_phase = 0; m_g = 0; m_last = N - 1; m_cnt = 0;
            m_wr = 1'b0; m_mask = '0; m_addr = '0; m_data = '0;
        end else if (m_phase == 0) begin
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (m_phase == 0 && ((|up_wr[p*WL +: WL]) || up_rd[p])) begin
                    m_phase = 1;
                    m_g     = p;
                    m_mask  = up_wr[p*WL +: WL];
                    m_wr    = |m_mask;
                    m_addr  = up_addr[p*AW +: AW];
                    m_data  = up_write_data[p*DW +: DW];
                    m_cnt   = 0;
                end
            end
        end else if (dn_error || to) begin
            m_phase = 0; m_last = m_g;
        end else if (m_phase == 1) begin
            if (dn_rdy) m_phase = 2;
            m_cnt++;
        end else begin
            if (m_wr ? dn_wvalid : dn_rvalid) begin
                m_phase = 0; m_last = m_g;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] oh;
        bit ending, to;
        to = m_timeout();
        oh = '0;
        oh[m_g] = 1'b1;
        ending = dn_error || to;
        check("model_dn_wr", dn_wr, (m_phase == 1 && m_wr) ? m_mask : 0);
        check("model_dn_rd", dn_rd, (m_phase == 1 && !m_wr) ? 1 : 0);
        check("model_dn_addr", dn_addr, m_addr);
        check("model_dn_write_data", dn_write_data, m_data);
        check("model_up_rdy", up_rdy, (m_phase == 1 && dn_rdy) ? oh : 0);
        check("model_up_error", up_error, (m_phase != 0 && ending) ? oh : 0);
        check("model_up_wvalid", up_wvalid,
              (m_phase == 2 && m_wr && dn_wvalid && !ending) ? oh : 0);
        check("model_up_rvalid", up_rvalid,
              (m_phase == 2 && !m_wr && dn_rvalid && !ending) ? oh : 0);
        check("model_grant_id", grant_id, m_g);
        check("model_up_read_data", up_read_data, dn_read_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (dn_wr == '0 && !dn_rd && n < 40);
        check({name, "_issued"}, (dn_wr != '0) || dn_rd, 1);
    endtask

    task automatic serve(input int exp_p, input bit wr, input logic [DW-1:0] rdata);
        wait_issue("serve");
        check("serve_grant_id", grant_id, exp_p);
        check("pin_model_grant", m_g, exp_p);
        dn_rdy = 1'b1;
        #1 check("serve_up_rdy", up_rdy, 1 << exp_p);
        tick();
        dn_rdy = 1'b0;
        if (wr) dn_wvalid = 1'b1;
        else begin
            dn_rvalid = 1'b1;
            dn_read_data = rdata;
        end
        #1;
        check("serve_done", wr ? up_wvalid : up_rvalid, 1 << exp_p);
        if (!wr) check("serve_read_data", up_read_data, rdata);
        tick();
        dn_wvalid = 1'b0;
        dn_rvalid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        check("reset_up_rdy", up_rdy, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_dn_rd", dn_rd, 0);
        rst = 1'b0;
        tick();

        // Port 2 write
        up_wr[2*WL +: WL] = 4'hF;
        up_addr[2*AW +: AW] = 32'h100;
        up_write_data[2*DW +: DW] = 32'hDEAD_BEEF;
        wait_issue("t1");
        up_wr = '0;
        check("t1_dn_wr", dn_wr, 4'hF);
        check("t1_dn_addr", dn_addr, 32'h100);
        check("t1_dn_write_data", dn_write_data, 32'hDEAD_BEEF);
        check("t1_grant_id", grant_id, 2);
        repeat (2) begin
            tick();
            check("t1_rdy_idle", up_rdy, 0);
        end
        dn_rdy = 1'b1;
        #1 check("t1_up_rdy", up_rdy, 4'b0100);
        tick();
        dn_rdy = 1'b0;
        check("t1_dn_wr_drop", dn_wr, 0);
        check("t1_rdy_single", up_rdy, 0);
        repeat (4) begin
            tick();
            check("t1_wvalid_idle", up_wvalid, 0);
        end
        dn_wvalid = 1'b1;
        #1 check("t1_up_wvalid", up_wvalid, 4'b0100);
        tick();
        dn_wvalid = 1'b0;
        check("t1_wvalid_single", up_wvalid, 0);

        // Reset, then all four ports read: 0,1,2,3,0
        rst = 1'b1; tick(); rst = 1'b0;
        up_rd = 4'hF;
        for (int i = 0; i < 5; i++) serve(i % N, 1'b0, 32'hA000_0000 + i);
        up_rd = '0;

        // Port 1 read ends in controller error
        up_rd[1] = 1'b1;
        wait_issue("t3");
        up_rd = '0;
        check("t3_grant_id", grant_id, 1);
        dn_rdy = 1'b1; tick(); dn_rdy = 1'b0;
        tick();
        dn_error = 1'b1;
        #1 check("t3_up_error", up_error, 4'b0010);
        tick();
        dn_error = 1'b0;
        check("t3_back_idle_rd", dn_rd, 0);
        check("t3_error_single", up_error, 0);
        up_wr[3*WL +: WL] = 4'h5;
        up_addr[3*AW +: AW] = 32'h40;
        serve(3, 1'b1, '0);
        up_wr = '0;

        // Reset mid-WAIT, late response dropped
        up_rd[2] = 1'b1;
        wait_issue("t4");
        up_rd = '0;
        dn_rdy = 1'b1; tick(); dn_rdy = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("t4_dn_rd", dn_rd, 0);
        check("t4_dn_addr", dn_addr, 0);
        check("t4_grant_id", grant_id, 0);
        tick();
        dn_rvalid = 1'b1;
        dn_read_data = 32'h1234_5678;
        #1 check("t4_late_rvalid", up_rvalid, 0);
        tick();
        dn_rvalid = 1'b0;
        up_rd = 4'hF;
        serve(0, 1'b0, 32'h5555_AAAA);
        up_rd = '0;

        // Port 0 write and read together: write wins
        up_wr[0 +: WL] = 4'h3;
        up_rd[0] = 1'b1;
        wait_issue("t5");
        up_wr = '0;
        up_rd = '0;
        check("t5_dn_wr", dn_wr, 4'h3);
        check("t5_dn_rd", dn_rd, 0);
        dn_rdy = 1'b1; tick(); dn_rdy = 1'b0;
        dn_rvalid = 1'b1;
        #1 check("t5_mismatch_rvalid", up_rvalid, 0);
        tick();
        dn_rvalid = 1'b0;
        dn_wvalid = 1'b1;
        #1 check("t5_up_wvalid", up_wvalid, 4'b0001);
        tick();
        dn_wvalid = 1'b1;
        #1 check("t5_idle_wvalid", up_wvalid, 0);
        tick();
        dn_wvalid = 1'b0;

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Watchdog: controller never responds
        up_rd[3] = 1'b1;
        wait_issue("t6");
        up_rd = '0;
        for (int c = 1; c < TO; c++) begin
            tick();
            check("t6_no_early_error", up_error, 0);
        end
        tick();
        check("t6_timeout_error", up_error, 4'b1000);
        tick();
        check("t6_back_idle", dn_rd, 0);
        check("t6_error_single", up_error, 0);
`endif

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
